// File: rtl/sonar_uc_varredura.sv
`default_nettype none
// ============================================================================
//  Module      : sonar_uc_varredura
//  Description : Control unit for a scanning sonar. For each servo angle it
//                waits for the servo to settle, requests a measurement with
//                bounded retries, and sends an 8-character frame before
//                stepping to the next angle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sonar_uc_varredura #(
    parameter int SETTLE_CYCLES  = 25000000,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       fim_medida,
    input  logic       fim_digito,
    input  logic       fim_envio,
    output logic       zera,
    output logic       medir,
    output logic       comeca_transmissao,
    output logic       conta_digito,
    output logic       conta_angulo,
    output logic       pronto,
    output logic       erro_medida,
    output logic [3:0] db_estado
);

    localparam int SETTLE_W  = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
    localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Terminal counts: the counter value seen on the last cycle in the state
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]           MAX_T        = 3'(MAX_TENTATIVAS);

    localparam logic [3:0] S_INICIAL        = 4'd0;
    localparam logic [3:0] S_PREPARA        = 4'd1;
    localparam logic [3:0] S_ESPERA_SERVO   = 4'd2;
    localparam logic [3:0] S_DISPARA        = 4'd3;
    localparam logic [3:0] S_ESPERA_MEDIDA  = 4'd4;
    localparam logic [3:0] S_TRANSMITE      = 4'd5;
    localparam logic [3:0] S_ESPERA_DIGITO  = 4'd6;
    localparam logic [3:0] S_PROXIMO_DIGITO = 4'd7;
    localparam logic [3:0] S_FIM_FRAME      = 4'd8;
    localparam logic [3:0] S_PROXIMO_ANGULO = 4'd9;

    logic [3:0]           state;
    logic [3:0]           next_state;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [TIMEOUT_W-1:0] timeout_cnt;
    logic [2:0]           tentativas;
    logic                 settle_done;
    logic                 timeout_done;
    logic                 tentativas_esgotadas;

    assign settle_done          = (settle_cnt == SETTLE_LAST);
    assign timeout_done         = (timeout_cnt == TIMEOUT_LAST);
    assign tentativas_esgotadas = (tentativas >= MAX_T);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_INICIAL;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; unused codes fall back to INICIAL
    always_comb begin
        next_state = S_INICIAL;
        case (state)
            S_INICIAL:        next_state = ligar ? S_PREPARA : S_INICIAL;
            S_PREPARA:        next_state = S_ESPERA_SERVO;
            S_ESPERA_SERVO:   next_state = settle_done ? S_DISPARA : S_ESPERA_SERVO;
            S_DISPARA:        next_state = S_ESPERA_MEDIDA;
            S_ESPERA_MEDIDA: begin
                // A measurement arriving on the timeout cycle still wins
                if (fim_medida)
                    next_state = S_TRANSMITE;
                else if (timeout_done)
                    next_state = tentativas_esgotadas ? S_TRANSMITE : S_DISPARA;
                else
                    next_state = S_ESPERA_MEDIDA;
            end
            S_TRANSMITE:      next_state = S_ESPERA_DIGITO;
            S_ESPERA_DIGITO: begin
                if (fim_digito)
                    next_state = fim_envio ? S_FIM_FRAME : S_PROXIMO_DIGITO;
                else
                    next_state = S_ESPERA_DIGITO;
            end
            S_PROXIMO_DIGITO: next_state = S_TRANSMITE;
            S_FIM_FRAME:      next_state = S_PROXIMO_ANGULO;
            S_PROXIMO_ANGULO: next_state = ligar ? S_ESPERA_SERVO : S_INICIAL;
            default:          next_state = S_INICIAL;
        endcase
    end

    // Moore output decode from the registered state
    always_comb begin
        zera               = 1'b0;
        medir              = 1'b0;
        comeca_transmissao = 1'b0;
        conta_digito       = 1'b0;
        conta_angulo       = 1'b0;
        pronto             = 1'b0;
        db_estado          = state;
        case (state)
            S_PREPARA:        zera               = 1'b1;
            S_DISPARA:        medir              = 1'b1;
            S_TRANSMITE:      comeca_transmissao = 1'b1;
            S_PROXIMO_DIGITO: conta_digito       = 1'b1;
            S_FIM_FRAME: begin
                // Extra count wraps the character counter back to 0
                conta_digito = 1'b1;
                pronto       = 1'b1;
            end
            S_PROXIMO_ANGULO: conta_angulo       = 1'b1;
            default:          db_estado          = state;
        endcase
    end

    // Settle counter: held at zero outside ESPERA_SERVO, saturates at terminal count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
        end else if (state != S_ESPERA_SERVO) begin
            settle_cnt <= '0;
        end else if (!settle_done) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    // Echo timeout counter: cleared on each trigger, saturates at terminal count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_cnt <= '0;
        end else if (state == S_DISPARA) begin
            timeout_cnt <= '0;
        end else if (state == S_ESPERA_MEDIDA && !timeout_done) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // Attempt counter: one count per trigger, cleared when a new angle begins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tentativas <= '0;
        end else if (state == S_PREPARA || state == S_PROXIMO_ANGULO) begin
            tentativas <= '0;
        end else if (state == S_DISPARA && tentativas != 3'd7) begin
            tentativas <= tentativas + 3'd1;
        end
    end

    // Sticky measurement error: updated only when leaving ESPERA_MEDIDA
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            erro_medida <= 1'b0;
        end else if (state == S_ESPERA_MEDIDA) begin
            if (fim_medida)
                erro_medida <= 1'b0;
            else if (timeout_done && tentativas_esgotadas)
                erro_medida <= 1'b1;
        end
    end

endmodule
`default_nettype wire
